// File: rtl/prbs16_checker.sv
// Receive-side checker for the x^16+x^14+x^13+x^11+1 Fibonacci PRBS stream.
// Seeds its history from the line, verifies the prediction, then counts bit errors against a flywheel.
module prbs16_checker #(
  parameter int LOCK_CNT    = 32,
  parameter int WIN         = 64,
  parameter int UNLOCK_ERRS = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clear_counts,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WIN + 1);
  localparam int EW = $clog2(UNLOCK_ERRS + 1);

  // Counters hold the number already seen, so "last" is the target minus one.
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(WIN - 1);
  localparam logic [EW-1:0] ERRS_LAST  = EW'(UNLOCK_ERRS - 1);

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t           r_state;
  logic [15:0]      r_hist;
  logic [3:0]       r_seed_cnt;
  logic [MW-1:0]    r_match_cnt;
  logic [WW-1:0]    r_win_bits;
  logic [EW-1:0]    r_win_errs;
  logic             r_err_pulse;
  logic [CNT_W-1:0] r_err_count;
  logic [CNT_W-1:0] r_bit_count;

  state_t           w_state_next;
  logic [15:0]      w_hist_next;
  logic [3:0]       w_seed_cnt_next;
  logic [MW-1:0]    w_match_cnt_next;
  logic [WW-1:0]    w_win_bits_next;
  logic [EW-1:0]    w_win_errs_next;
  logic             w_err_pulse_next;
  logic [CNT_W-1:0] w_err_count_next;
  logic [CNT_W-1:0] w_bit_count_next;

  logic             w_pred;
  logic             w_mis;
  logic [15:0]      w_hist_din;
  logic [15:0]      w_hist_pred;
  logic             w_err_max;
  logic             w_bit_max;

  assign w_pred      = r_hist[15] ^ r_hist[13] ^ r_hist[12] ^ r_hist[10];
  assign w_mis       = din ^ w_pred;
  assign w_hist_din  = {r_hist[14:0], din};
  assign w_hist_pred = {r_hist[14:0], w_pred};
  assign w_err_max   = &r_err_count;
  assign w_bit_max   = &r_bit_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_SEED;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_hist_next      = r_hist;
    w_seed_cnt_next  = r_seed_cnt;
    w_match_cnt_next = r_match_cnt;
    w_win_bits_next  = r_win_bits;
    w_win_errs_next  = r_win_errs;
    w_err_pulse_next = 1'b0;
    w_err_count_next = r_err_count;
    w_bit_count_next = r_bit_count;

    if (din_valid) begin
      case (r_state)
        ST_SEED: begin
          w_hist_next     = w_hist_din;
          w_seed_cnt_next = r_seed_cnt + 4'd1;
          // 16th bit wraps the counter to 0; an all-zero history means a stuck-0 line.
          if (r_seed_cnt == 4'd15 && w_hist_din != 16'd0) begin
            w_state_next     = ST_VERIFY;
            w_match_cnt_next = '0;
          end
        end

        ST_VERIFY: begin
          w_hist_next = w_hist_din;
          if (!w_mis) begin
            if (r_match_cnt == MATCH_LAST) begin
              w_state_next     = ST_LOCKED;
              w_match_cnt_next = '0;
              w_win_bits_next  = '0;
              w_win_errs_next  = '0;
            end else begin
              w_match_cnt_next = r_match_cnt + 1'b1;
            end
          end else begin
            w_state_next    = ST_SEED;
            w_seed_cnt_next = 4'd0;
          end
        end

        ST_LOCKED: begin
          // Flywheel: the prediction is shifted in so one line error is counted once.
          w_hist_next = w_hist_pred;
          if (!w_bit_max) begin
            w_bit_count_next = r_bit_count + 1'b1;
          end
          if (w_mis) begin
            w_err_pulse_next = 1'b1;
            if (!w_err_max) begin
              w_err_count_next = r_err_count + 1'b1;
            end
          end
          if (w_mis && r_win_errs == ERRS_LAST) begin
            w_state_next    = ST_SEED;
            w_seed_cnt_next = 4'd0;
            w_win_bits_next = '0;
            w_win_errs_next = '0;
          end else if (r_win_bits == WIN_LAST) begin
            w_win_bits_next = '0;
            w_win_errs_next = '0;
          end else begin
            w_win_bits_next = r_win_bits + 1'b1;
            w_win_errs_next = r_win_errs + EW'(w_mis);
          end
        end

        default: begin
          w_state_next    = ST_SEED;
          w_seed_cnt_next = 4'd0;
        end
      endcase
    end

    if (clear_counts) begin
      w_err_count_next = '0;
      w_bit_count_next = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist      <= 16'd0;
      r_seed_cnt  <= 4'd0;
      r_match_cnt <= '0;
      r_win_bits  <= '0;
      r_win_errs  <= '0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
      r_bit_count <= '0;
    end else begin
      r_hist      <= w_hist_next;
      r_seed_cnt  <= w_seed_cnt_next;
      r_match_cnt <= w_match_cnt_next;
      r_win_bits  <= w_win_bits_next;
      r_win_errs  <= w_win_errs_next;
      r_err_pulse <= w_err_pulse_next;
      r_err_count <= w_err_count_next;
      r_bit_count <= w_bit_count_next;
    end
  end

  assign locked    = (r_state == ST_LOCKED);
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;
  assign bit_count = r_bit_count;

endmodule
